// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the CPU front end.
package cpu_pkg;
  typedef enum logic {IDLE, RUN} fetch_state_t;
  localparam int INST_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam logic [31:0] NOP_INST = 32'h0;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous circular FIFO with push, pop, clear and occupancy count.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i && !clear_i) mem_d[wptr_q] = data_i;
    wptr_d = clear_i ? '0 : wptr_q + AW'(push_i);
    rptr_d = clear_i ? '0 : rptr_q + AW'(pop_i);
    count_d = clear_i ? '0 : count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  assign data_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, prefetch queue and valid/ready handshake toward decode.
module fetch_unit import cpu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_req_o,
  input  logic [INST_W-1:0] imem_inst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              ifid_valid_o,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  input  logic              ifid_ready_i,
  output logic [CW-1:0]     count_o
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc4;
  logic run, deq, pop, clear;
  logic unused_pc_bits;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  always_comb begin
    state_d = start_i ? RUN : IDLE;
  end
  // Redirect outranks everything; in IDLE it only moves the PC.
  always_comb begin
    run = state_q == RUN;
    pc4 = pc_q + ADDR_W'(4);
    deq = ifid_valid_o & ifid_ready_i;
    pop = deq & ~redirect_i;
    clear = redirect_i & run;
    imem_req_o = run & start_i & ~redirect_i & ((count_o < CW'(DEPTH)) | deq);
    pc_d = redirect_i ? {redirect_pc_i[ADDR_W-1:2], 2'b00} : imem_req_o ? pc4 : pc_q;
  end
  fetch_queue #(.WIDTH(INST_W + ADDR_W), .DEPTH(DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (imem_req_o),
    .pop_i   (pop),
    .clear_i (clear),
    .data_i  ({imem_inst_i, pc4}),
    .data_o  ({ifid_inst_o, ifid_pc4_o}),
    .count_o (count_o)
  );
  assign imem_addr_o = pc_q;
  assign ifid_valid_o = count_o != '0;
  assign unused_pc_bits = ^redirect_pc_i[1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit, plus a PC-wrap instance.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] inst; logic [31:0] pc4;} ent_t;
  logic clk = 0, rst_n = 0, start = 0, redir = 0, ready = 0;
  logic [31:0] rpc = 0;
  logic [31:0] addr, inst, pc4, addr2, inst2, pc42;
  logic req, valid, req2, valid2;
  logic [2:0] count, count2;
  int checks = 0, errors = 0;
  ent_t sb[$];
  logic m_run = 0;
  logic [31:0] m_pc = 0;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .imem_addr_o(addr), .imem_req_o(req),
    .imem_inst_i(addr >> 2), .redirect_i(redir), .redirect_pc_i(rpc), .ifid_valid_o(valid),
    .ifid_inst_o(inst), .ifid_pc4_o(pc4), .ifid_ready_i(ready), .count_o(count)
  );
  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .imem_addr_o(addr2), .imem_req_o(req2),
    .imem_inst_i(addr2 >> 2), .redirect_i(1'b0), .redirect_pc_i(32'h0), .ifid_valid_o(valid2),
    .ifid_inst_o(inst2), .ifid_pc4_o(pc42), .ifid_ready_i(1'b1), .count_o(count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_deq();
    return sb.size() != 0 && ready && !redir;
  endfunction

  function automatic logic m_fetch();
    return m_run && start && !redir && (sb.size() < DEPTH || m_deq());
  endfunction

  task automatic check_cycle();
    chk("req", req, m_fetch());
    chk("addr", addr, m_pc);
    chk("cnt", count, sb.size());
    chk("vld", valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("inst", inst, sb[0].inst);
      chk("pc4", pc4, sb[0].pc4);
    end
  endtask

  task automatic update_model();
    logic f, d;
    f = m_fetch();
    d = m_deq();
    if (redir) begin
      m_pc = {rpc[31:2], 2'b00};
      if (m_run) sb.delete();
    end else begin
      if (d) void'(sb.pop_front());
      if (f) begin
        sb.push_back('{inst: m_pc >> 2, pc4: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = start;
  endtask

  task automatic tick(input logic s, input logic r, input logic d, input logic [31:0] p);
    @(posedge clk);
    update_model();
    #1;
    start = s;
    ready = r;
    redir = d;
    rpc = p;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic reset_dut();
    rst_n = 0;
    start = 0;
    ready = 0;
    redir = 0;
    sb.delete();
    m_pc = 0;
    m_run = 0;
    @(negedge clk);
    chk("rst_cnt", count, 0);
    chk("rst_vld", valid, 0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    reset_dut();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    chk("wrap_req", req2, 1);
    tick(1, 1, 0, 0);
    chk("wrap_addr1", addr2, 32'h0);
    chk("wrap_pc4", pc42, 32'h0);
    chk("wrap_inst", inst2, 32'h3FFF_FFFF);
    chk("wrap_vld", valid2, 1);
    chk("wrap_cnt", count2, 1);
    repeat (8) tick(1, 1, 0, 0);
    chk("steady_cnt", count, 1);

    reset_dut();
    repeat (7) tick(1, 0, 0, 0);
    chk("full_cnt", count, 4);
    chk("full_req", req, 0);
    chk("full_addr", addr, 32'h10);
    repeat (4) tick(1, 1, 0, 0);
    chk("full_pop_cnt", count, 4);
    chk("full_pop_req", req, 1);
    repeat (6) tick(1, 1, 0, 0);

    reset_dut();
    repeat (5) tick(1, 0, 0, 0);
    chk("pre_redir_cnt", count, 3);
    tick(1, 1, 1, 32'h103);
    tick(1, 1, 0, 0);
    chk("redir_vld", valid, 0);
    chk("redir_cnt", count, 0);
    chk("redir_addr", addr, 32'h100);
    tick(1, 1, 0, 0);
    chk("redir_pc4", pc4, 32'h104);
    repeat (4) tick(1, 1, 0, 0);

    reset_dut();
    repeat (4) tick(1, 0, 0, 0);
    chk("mid_cnt", count, 2);
    rst_n = 0;
    #1;
    chk("async_cnt", count, 0);
    chk("async_vld", valid, 0);
    chk("async_inst", inst, 0);
    chk("async_pc4", pc4, 0);
    chk("async_addr", addr, 0);
    chk("async_req", req, 0);

    reset_dut();
    repeat (5) tick(1, 0, 0, 0);
    repeat (6) tick(0, 1, 0, 0);
    chk("drain_cnt", count, 0);
    tick(0, 0, 1, 32'h202);
    tick(0, 0, 0, 0);
    chk("idle_redir_addr", addr, 32'h200);

    repeat (300)
      tick($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0,
           $urandom & 32'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the pipelined CPU. It replaces the bare PC/IF-ID register pair with a PC register, a DEPTH-entry prefetch queue and a valid/ready handshake toward decode. Decode stalls by dropping ready instead of gating PCWrite. Branch/jump redirects from later stages flush the queue and restart fetch at a new address. It sits between Instruction_Memory (combinational read) and the decode stage.

## Interface
- ADDR_W, 32, PC and instruction-address width
- INST_W, 32, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, at least 2
- RESET_PC, 0, PC value after reset; word aligned

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- start_i  in  1  fetch enable; level-sensitive
- imem_addr_o  out  ADDR_W  instruction memory address (= PC)
- imem_req_o  out  1  a fetch is performed this cycle
- imem_inst_i  in  INST_W  instruction at imem_addr_o, valid in the same cycle
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  ADDR_W  restart address; bits [1:0] ignored (forced 0)
- ifid_valid_o  out  1  head entry valid
- ifid_inst_o  out  INST_W  head instruction
- ifid_pc4_o  out  ADDR_W  head instruction address + 4
- ifid_ready_i  in  1  decode accepts the head this cycle
- count_o  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- FSM states:
  - IDLE: reset state. Moves to RUN on a cycle with start_i=1.
  - RUN: returns to IDLE on a cycle with start_i=0. Queue contents are kept and continue to drain.
- Dequeue (deq) = ifid_valid_o & ifid_ready_i.
- Fetch (imem_req_o) = state==RUN & start_i & !redirect_i & (count<DEPTH | deq).
  - On fetch: push {imem_inst_i, PC+4}, then PC <= PC+4.
  - PC+4 wraps modulo 2^ADDR_W; no overflow flag.
- Full queue with deq in the same cycle: push and pop both happen; count is unchanged.
- Empty queue: ifid_valid_o=0. ifid_inst_o/ifid_pc4_o hold their last values, which are don't-care.
- Redirect has the highest priority:
  - queue cleared, count=0;
  - PC <= {redirect_pc_i[ADDR_W-1:2],2'b00};
  - no fetch and no pop that cycle; ifid_ready_i is ignored.
  - A redirect in IDLE updates the PC only.
- imem_addr_o is driven from the PC register at all times.
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits plus a count. Pointers wrap DEPTH-1 -> 0.

## Timing
- Reset values: PC=RESET_PC, state=IDLE, count_o=0, ifid_valid_o=0, ifid_inst_o=0, ifid_pc4_o=0, imem_req_o=0. Pointers are 0.
- Asserting reset mid-operation discards queue contents immediately, without waiting for a clock edge.
- Fetch-to-decode latency: an instruction fetched in cycle N is at the head in cycle N+1 if the queue was empty.
- Redirect in cycle N:
  - ifid_valid_o=0 in N+1;
  - fetch of redirect_pc_i in N+1;
  - that instruction is at the head in N+2.
- Steady state with ifid_ready_i=1: one instruction per cycle and count_o stays at 1.
- Outputs ifid_* and count_o are registered. imem_req_o is combinational from state, start_i, redirect_i, count and deq.

## Structure
- Shared package cpu_pkg holds:
  - fetch_state_t {IDLE, RUN};
  - the INST_W/ADDR_W defaults;
  - NOP_INST = 32'h0.
- One sub-module: fetch_queue, a parametrised synchronous circular FIFO (WIDTH=INST_W+ADDR_W, DEPTH) with push, pop, clear, count.
- The FSM and PC logic stay in fetch_unit.

## Test plan
- Reset, start_i=1, ready=1, memory word i = i: head shows inst 0,1,2,… with pc4 4,8,12,… one per cycle from cycle 2. count_o stays 1.
- ready=0 for 6 cycles from reset+start (DEPTH=4):
  - count_o goes 1,2,3,4 and holds 4;
  - imem_req_o=0 while full;
  - imem_addr_o holds 0x10.
  - Then ready=1: heads 0,1,2,3,4 in order with no gap or duplicate.
- Queue full and ready=1: count_o stays 4, and push and pop occur in the same cycle.
- redirect_i with redirect_pc_i=0x103 while count=3:
  - next cycle valid=0 and count=0;
  - imem_addr_o=0x100;
  - head pc4=0x104 one cycle later.
- PC wrap: RESET_PC=32'hFFFFFFFC; the first head has pc4=0 and the second fetch address is 0.
- Mid-run resets and halts:
  - rst_n_i dropped mid-cycle with count=2: outputs return to reset values immediately.
  - start_i=0 mid-run: fetch stops and the queue drains to 0.
